// File: rtl/ball_motion_ctrl.sv
// Ball motion engine for one billiard ball. It holds the ball's fixed-point
// position and velocity, builds up a shot vector from the charge keys,
// integrates the ball once per frame, and handles pocketing and respawn.
//
// state  | meaning
// -------+------------------------------------------------------------
// AIM    | ball at rest; charge keys build the shot, releaseBall fires it
// ROLL   | ball moving; edge reflection, per-frame integration, friction
// POCKET | ball hidden in a pocket until respawn
module ball_motion_ctrl #(
  parameter int FRAC_BITS  = 6,
  parameter int SPEED_W    = 12,
  parameter int POS_W      = 11,
  parameter int INIT_X     = 100,
  parameter int INIT_Y     = 220,
  parameter int SPEED_STEP = 200,
  parameter int MAX_SHOT   = 1000,
  parameter int FRICTION   = 4,
  parameter int MIN_SPEED  = 2,
  parameter int X_MIN      = 0,
  parameter int X_MAX      = 607,
  parameter int Y_MIN      = 0,
  parameter int Y_MAX      = 447
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      startOfFrame,
  input  logic                      chargeUp,
  input  logic                      chargeDown,
  input  logic                      chargeLeft,
  input  logic                      chargeRight,
  input  logic                      releaseBall,
  input  logic                      collision,
  input  logic [3:0]                HitEdgeCode,
  input  logic                      pocketed,
  input  logic                      respawn,
  output logic signed [POS_W-1:0]   topLeftX,
  output logic signed [POS_W-1:0]   topLeftY,
  output logic signed [SPEED_W-1:0] shotX,
  output logic signed [SPEED_W-1:0] shotY,
  output logic                      moving,
  output logic                      hidden,
  output logic                      shotDone
);

  localparam int POS_FW = POS_W + FRAC_BITS;
  localparam int SUM_W  = POS_FW + 1;
  localparam int SHOT_W = SPEED_W + 2;

  localparam logic signed [POS_FW-1:0]  INIT_X_FP = POS_FW'(INIT_X <<< FRAC_BITS);
  localparam logic signed [POS_FW-1:0]  INIT_Y_FP = POS_FW'(INIT_Y <<< FRAC_BITS);
  localparam logic signed [SUM_W-1:0]   X_LO      = SUM_W'(X_MIN <<< FRAC_BITS);
  localparam logic signed [SUM_W-1:0]   X_HI      = SUM_W'(X_MAX <<< FRAC_BITS);
  localparam logic signed [SUM_W-1:0]   Y_LO      = SUM_W'(Y_MIN <<< FRAC_BITS);
  localparam logic signed [SUM_W-1:0]   Y_HI      = SUM_W'(Y_MAX <<< FRAC_BITS);
  localparam logic signed [SHOT_W-1:0]  STEP_V    = SHOT_W'(SPEED_STEP);
  localparam logic signed [SHOT_W-1:0]  SHOT_HI   = SHOT_W'(MAX_SHOT);
  localparam logic signed [SHOT_W-1:0]  SHOT_LO   = SHOT_W'(-MAX_SHOT);
  localparam logic signed [SPEED_W-1:0] FRIC_V    = SPEED_W'(FRICTION);
  localparam logic signed [SPEED_W-1:0] MIN_V     = SPEED_W'(MIN_SPEED);

  typedef enum logic [1:0] {
    AIM    = 2'd0,
    ROLL   = 2'd1,
    POCKET = 2'd2
  } stateT;

  stateT                      state, stateNext;
  logic signed [POS_FW-1:0]   posX, posY, posXNext, posYNext;
  logic signed [SPEED_W-1:0]  speedX, speedY, speedXNext, speedYNext;
  logic signed [SPEED_W-1:0]  shotXNext, shotYNext;
  logic                       shotDoneNext;

  logic signed [SPEED_W-1:0]  reflX, reflY, fricX, fricY, frameVx, frameVy;
  logic signed [SUM_W-1:0]    sumX, sumY;
  logic signed [POS_FW-1:0]   frameX, frameY;

  // Adds/subtracts one charge step on an axis, saturating at +/-MAX_SHOT.
  // Widened accumulator so the overshoot is visible before clamping.
  function automatic logic signed [SPEED_W-1:0] chargeAxis(
    input logic signed [SPEED_W-1:0] cur,
    input logic                      inc,
    input logic                      dec
  );
    logic signed [SHOT_W-1:0] acc;
    acc = {{(SHOT_W-SPEED_W){cur[SPEED_W-1]}}, cur};
    if (inc) acc = acc + STEP_V;
    if (dec) acc = acc - STEP_V;
    if (acc > SHOT_HI) acc = SHOT_HI;
    else if (acc < SHOT_LO) acc = SHOT_LO;
    return acc[SPEED_W-1:0];
  endfunction

  // Negates a speed only when it is heading into the edge that was hit.
  function automatic logic signed [SPEED_W-1:0] reflectAxis(
    input logic signed [SPEED_W-1:0] v,
    input logic                      hitLow,
    input logic                      hitHigh
  );
    logic isNeg, isPos;
    isNeg = v[SPEED_W-1];
    isPos = !isNeg && (v != '0);
    if ((hitLow && isNeg) || (hitHigh && isPos)) return -v;
    return v;
  endfunction

  // Sign-preserving friction; slow axes snap to zero instead of crossing it.
  function automatic logic signed [SPEED_W-1:0] frictionAxis(
    input logic signed [SPEED_W-1:0] v
  );
    logic signed [SPEED_W-1:0] mag;
    mag = v[SPEED_W-1] ? -v : v;
    if (mag > MIN_V && mag > FRIC_V) return v[SPEED_W-1] ? v + FRIC_V : v - FRIC_V;
    return '0;
  endfunction

  // Next-state and datapath update: reflection, frame integration, clamping, pocketing.
  always_comb begin
    stateNext    = state;
    posXNext     = posX;
    posYNext     = posY;
    speedXNext   = speedX;
    speedYNext   = speedY;
    shotXNext    = shotX;
    shotYNext    = shotY;
    shotDoneNext = 1'b0;

    reflX = reflectAxis(speedX, collision & HitEdgeCode[3], collision & HitEdgeCode[1]);
    reflY = reflectAxis(speedY, collision & HitEdgeCode[2], collision & HitEdgeCode[0]);
    fricX = frictionAxis(reflX);
    fricY = frictionAxis(reflY);

    // Position integrates the speed held at the start of the cycle, not the reflected one.
    sumX = {posX[POS_FW-1], posX} + {{(SUM_W-SPEED_W){speedX[SPEED_W-1]}}, speedX};
    sumY = {posY[POS_FW-1], posY} + {{(SUM_W-SPEED_W){speedY[SPEED_W-1]}}, speedY};

    frameX  = sumX[POS_FW-1:0];
    frameVx = fricX;
    if (sumX > X_HI) begin
      frameX  = X_HI[POS_FW-1:0];
      frameVx = '0;
    end else if (sumX < X_LO) begin
      frameX  = X_LO[POS_FW-1:0];
      frameVx = '0;
    end

    frameY  = sumY[POS_FW-1:0];
    frameVy = fricY;
    if (sumY > Y_HI) begin
      frameY  = Y_HI[POS_FW-1:0];
      frameVy = '0;
    end else if (sumY < Y_LO) begin
      frameY  = Y_LO[POS_FW-1:0];
      frameVy = '0;
    end

    case (state)
      AIM: begin
        if (pocketed) begin
          stateNext  = POCKET;
          speedXNext = '0;
          speedYNext = '0;
          shotXNext  = '0;
          shotYNext  = '0;
        end else if (releaseBall && (shotX != '0 || shotY != '0)) begin
          stateNext  = ROLL;
          speedXNext = shotX;
          speedYNext = shotY;
          shotXNext  = '0;
          shotYNext  = '0;
        end else begin
          shotXNext = chargeAxis(shotX, chargeLeft, chargeRight);
          shotYNext = chargeAxis(shotY, chargeUp, chargeDown);
        end
      end
      ROLL: begin
        if (pocketed) begin
          stateNext  = POCKET;
          speedXNext = '0;
          speedYNext = '0;
          shotXNext  = '0;
          shotYNext  = '0;
        end else if (startOfFrame) begin
          posXNext   = frameX;
          posYNext   = frameY;
          speedXNext = frameVx;
          speedYNext = frameVy;
          if (frameVx == '0 && frameVy == '0) begin
            stateNext    = AIM;
            shotDoneNext = 1'b1;
          end
        end else begin
          speedXNext = reflX;
          speedYNext = reflY;
        end
      end
      POCKET: begin
        if (respawn && !pocketed) begin
          stateNext = AIM;
          posXNext  = INIT_X_FP;
          posYNext  = INIT_Y_FP;
        end
      end
      default: stateNext = AIM;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= AIM;
      posX     <= INIT_X_FP;
      posY     <= INIT_Y_FP;
      speedX   <= '0;
      speedY   <= '0;
      shotX    <= '0;
      shotY    <= '0;
      shotDone <= 1'b0;
    end else begin
      state    <= stateNext;
      posX     <= posXNext;
      posY     <= posYNext;
      speedX   <= speedXNext;
      speedY   <= speedYNext;
      shotX    <= shotXNext;
      shotY    <= shotYNext;
      shotDone <= shotDoneNext;
    end
  end

  // Arithmetic shift right by FRAC_BITS is just the upper slice of the position.
  assign topLeftX = posX[POS_FW-1:FRAC_BITS];
  assign topLeftY = posY[POS_FW-1:FRAC_BITS];
  assign moving   = (state == ROLL);
  assign hidden   = (state == POCKET);

endmodule
